// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Optional counters are enabled with the WR_ARB_COUNT_EN macro.
package regfile_pkg;

  typedef logic [3:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  // Register index owned by the program counter; never written via this port.
  localparam reg_addr_t PC_IDX = 4'd15;

  // Width of the optional per-requester acceptance counters.
  localparam int unsigned CNT_W = 16;

  // Records which requester was granted most recently.
  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } arb_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of requester handshakes and the register-file write port.
// cnt0/cnt1 exist only when WR_ARB_COUNT_EN is defined.
interface regfile_wr_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
);

  logic          hold;

  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;

  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;

  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic          pc_wr_err;

`ifdef WR_ARB_COUNT_EN
  logic [15:0]   cnt0;
  logic [15:0]   cnt1;
`endif

  // Pipeline side: drives requests, observes grants and the write port.
  modport master (
    output hold,
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
`ifdef WR_ARB_COUNT_EN
    input  cnt0, cnt1,
`endif
    input  we3, wa3, wd3, pc_wr_err
  );

  // Arbiter side.
  modport slave (
    input  hold,
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
`ifdef WR_ARB_COUNT_EN
    output cnt0, cnt1,
`endif
    output we3, wa3, wd3, pc_wr_err
  );

endinterface

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-input round-robin grant generator: one-hot grant from the already
// qualified valids and the last-granted state.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] valid_i,
  input  arb_state_t last_i,
  output logic [1:0] grant_o
);

  // A lone requester wins; on contention the one not granted last wins.
  always_comb begin
    grant_o = '0;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_i == LAST0) ? 2'b10 : 2'b01;
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: round-robin between the ALU (req0) and
// load (req1) writeback paths, one registered write per cycle, with writes
// to the PC index dropped and flagged on pc_wr_err.
// Defining WR_ARB_COUNT_EN adds saturating accepted-write counters.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned   DW     = 32,
  parameter int unsigned   AW     = 4,
  parameter logic [AW-1:0] PC_IDX = AW'(regfile_pkg::PC_IDX)
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  bus
);

  arb_state_t    state_q, state_d;
  logic [1:0]    vld;
  logic [1:0]    grant;
  logic          acc;
  logic          pc_hit;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  logic          we3_q, we3_d;
  logic [AW-1:0] wa3_q, wa3_d;
  logic [DW-1:0] wd3_q, wd3_d;
  logic          err_q, err_d;

  // Nothing is accepted during reset or a stall.
  assign vld = {bus.req1_valid, bus.req0_valid} & {2{rst & ~bus.hold}};

  rr_arb2 u_arb (
    .valid_i (vld),
    .last_i  (state_q),
    .grant_o (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  assign acc      = |grant;
  assign sel_addr = grant[1] ? bus.req1_addr : bus.req0_addr;
  assign sel_data = grant[1] ? bus.req1_data : bus.req0_data;
  assign pc_hit   = (sel_addr == PC_IDX);

  // Last-grant state register; reset favours req0 on the first contest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LAST1;
    else      state_q <= state_d;
  end

  // Next state follows the grant; idle cycles keep the history.
  always_comb begin
    state_d = state_q;
    if (grant[0])      state_d = LAST0;
    else if (grant[1]) state_d = LAST1;
  end

  // Next write-port values; a PC-targeted request is consumed but not written.
  always_comb begin
    we3_d = 1'b0;
    err_d = 1'b0;
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (acc) begin
      if (pc_hit) begin
        err_d = 1'b1;
      end else begin
        we3_d = 1'b1;
        wa3_d = sel_addr;
        wd3_d = sel_data;
      end
    end
  end

  // Write-port register; async reset discards any pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we3_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
      err_q <= 1'b0;
    end else begin
      we3_q <= we3_d;
      wa3_q <= wa3_d;
      wd3_q <= wd3_d;
      err_q <= err_d;
    end
  end

  assign bus.we3       = we3_q;
  assign bus.wa3       = wa3_q;
  assign bus.wd3       = wd3_q;
  assign bus.pc_wr_err = err_q;

`ifdef WR_ARB_COUNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Count accepted, non-rejected writes per requester, saturating at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (acc && !pc_hit) begin
      if (grant[0] && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
      if (grant[1] && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
    end
  end

  // Counter registers, updated on the same edge as we3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_regfile_wr_arbiter;

  logic clk;
  logic rst;

  regfile_wr_arbiter_if #(.DW(32), .AW(4)) bus ();

  regfile_wr_arbiter #(.DW(32), .AW(4), .PC_IDX(4'd15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: last grant (1 = req1 granted last), expected write port.
  bit          m_last = 1'b1;
  bit          m_we   = 1'b0;
  bit [3:0]    m_wa   = '0;
  bit [31:0]   m_wd   = '0;
  bit          m_err  = 1'b0;
  bit          m_acc0 = 1'b0;
  bit          m_acc1 = 1'b0;
  int unsigned m_c0   = 0;
  int unsigned m_c1   = 0;

  function automatic bit want0(input bit last);
    return rst && bus.req0_valid && !bus.hold && (!bus.req1_valid || last);
  endfunction
  function automatic bit want1(input bit last);
    return rst && bus.req1_valid && !bus.hold && (!bus.req0_valid || !last);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_last = 1'b1; m_we = 1'b0; m_wa = '0; m_wd = '0; m_err = 1'b0;
      m_acc0 = 1'b0; m_acc1 = 1'b0; m_c0 = 0; m_c1 = 0;
    end else begin
      bit       g0, g1;
      bit [3:0] a;
      g0 = want0(m_last);
      g1 = want1(m_last);
      m_acc0 = g0;
      m_acc1 = g1;
      m_we  = 1'b0;
      m_err = 1'b0;
      if (g0 || g1) begin
        a = g1 ? bus.req1_addr : bus.req0_addr;
        m_last = g1;
        if (a == 4'd15) begin
          m_err = 1'b1;
        end else begin
          m_we = 1'b1;
          m_wa = a;
          m_wd = g1 ? bus.req1_data : bus.req0_data;
          if (g0 && m_c0 < 32'hFFFF) m_c0++;
          if (g1 && m_c1 < 32'hFFFF) m_c1++;
        end
      end
    end
  end

  // Compare every output against the model each cycle, away from the edge.
  always @(negedge clk) begin
    chk("req0_ready", {31'b0, bus.req0_ready}, {31'b0, want0(m_last)});
    chk("req1_ready", {31'b0, bus.req1_ready}, {31'b0, want1(m_last)});
    chk("we3",        {31'b0, bus.we3},        {31'b0, m_we});
    chk("wa3",        {28'b0, bus.wa3},        {28'b0, m_wa});
    chk("wd3",        bus.wd3,                 m_wd);
    chk("pc_wr_err",  {31'b0, bus.pc_wr_err},  {31'b0, m_err});
`ifdef WR_ARB_COUNT_EN
    chk("cnt0", {16'b0, bus.cnt0}, m_c0);
    chk("cnt1", {16'b0, bus.cnt1}, m_c1);
`endif
  end

  initial begin
    rst = 1'b1;
    bus.hold = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    #1;
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd1; bus.req0_data = 32'd7;

    // Reset holds everything idle even with a valid request.
    @(negedge clk);
    chk("lit_rst_ready0", {31'b0, bus.req0_ready}, 32'd0);
    chk("lit_rst_we3",    {31'b0, bus.we3},        32'd0);
    chk("lit_rst_wa3",    {28'b0, bus.wa3},        32'd0);
    chk("lit_rst_wd3",    bus.wd3,                 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Single write.
    @(negedge clk);
    chk("lit_single_ready0", {31'b0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("lit_single_we3", {31'b0, bus.we3}, 32'd1);
    chk("lit_single_wa3", {28'b0, bus.wa3}, 32'd1);
    chk("lit_single_wd3", bus.wd3,          32'd7);

    // Contention after a req0 grant: req1 first, then alternating.
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd3; bus.req0_data = 32'hA;
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd4; bus.req1_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lit_cont_ready1", {31'b0, bus.req1_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("lit_cont_ready0", {31'b0, bus.req0_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) begin
        chk("lit_cont_we3", {31'b0, bus.we3}, 32'd1);
        chk("lit_cont_wa3", {28'b0, bus.wa3}, (i % 2 == 1) ? 32'd4 : 32'd3);
      end
    end

    // Asynchronous reset between edges while a write is on the port.
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("lit_async_we3", {31'b0, bus.we3}, 32'd0);
    chk("lit_async_wa3", {28'b0, bus.wa3}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("lit_post_rst_ready0", {31'b0, bus.req0_ready}, 32'd1);
    chk("lit_post_rst_ready1", {31'b0, bus.req1_ready}, 32'd0);
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("lit_post_rst_ready1b", {31'b0, bus.req1_ready}, 32'd1);
    chk("lit_post_rst_wa3",     {28'b0, bus.wa3},        32'd3);

    // PC-targeted write is consumed and flagged, not written.
    @(posedge clk); #1 bus.req1_addr = 4'd15; bus.req1_data = 32'h100;
    @(negedge clk);
    chk("lit_pc_ready1", {31'b0, bus.req1_ready}, 32'd1);
    chk("lit_pc_pre_wa3", {28'b0, bus.wa3}, 32'd4);
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("lit_pc_we3", {31'b0, bus.we3},       32'd0);
    chk("lit_pc_err", {31'b0, bus.pc_wr_err}, 32'd1);
    chk("lit_pc_wa3", {28'b0, bus.wa3},       32'd4);
    chk("lit_pc_wd3", bus.wd3,                32'hB);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lit_pc_err_pulse", {31'b0, bus.pc_wr_err}, 32'd0);

    // Stall: nothing accepted; req0 is due after release (req1 went last).
    @(posedge clk); #1;
    bus.hold = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd5; bus.req0_data = 32'h55;
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd6; bus.req1_data = 32'h66;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lit_hold_ready0", {31'b0, bus.req0_ready}, 32'd0);
      chk("lit_hold_ready1", {31'b0, bus.req1_ready}, 32'd0);
      chk("lit_hold_we3",    {31'b0, bus.we3},        32'd0);
      if (k < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1 bus.hold = 1'b0;
    @(negedge clk);
    chk("lit_release_ready0", {31'b0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("lit_release_ready1", {31'b0, bus.req1_ready}, 32'd1);
    chk("lit_release_wa3",    {28'b0, bus.wa3},        32'd5);
    chk("lit_release_wd3",    bus.wd3,                 32'h55);
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("lit_release_wa3b", {28'b0, bus.wa3}, 32'd6);
    chk("lit_release_wd3b", bus.wd3,          32'h66);

    // Randomized traffic; requesters hold a request until the model accepts it.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
      end
      if (!bus.req0_valid || m_acc0) begin
        bus.req0_valid = ($urandom_range(0, 9) < 6);
        bus.req0_addr  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
        bus.req0_data  = $urandom;
      end
      if (!bus.req1_valid || m_acc1) begin
        bus.req1_valid = ($urandom_range(0, 9) < 6);
        bus.req1_addr  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
        bus.req1_data  = $urandom;
      end
      bus.hold = ($urandom_range(0, 7) == 0);
    end

    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (we3/wa3/wd3) between two writeback requesters: req0 = execute/ALU result, req1 = memory/load result.
- Uses round-robin arbitration with valid/ready handshakes.
- Registers the granted write toward the register file.
- Rejects writes to R15, which is driven separately through the r15 input of the register file.

Parameters:
- DW, 32, data width of write data
- AW, 4, register address width (16 registers)
- PC_IDX, 15, address reserved for the program counter; writes to it are rejected

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- hold  in  1  pipeline stall; while 1, no request is accepted
- req0_valid  in  1  requester 0 has a write pending
- req0_addr  in  AW  requester 0 destination register
- req0_data  in  DW  requester 0 write data
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid  in  1  requester 1 has a write pending
- req1_addr  in  AW  requester 1 destination register
- req1_data  in  DW  requester 1 write data
- req1_ready  out  1  requester 1 accepted this cycle
- we3  out  1  register-file write enable
- wa3  out  AW  register-file write address
- wd3  out  DW  register-file write data
- pc_wr_err  out  1  one-cycle pulse: an accepted request targeted PC_IDX and was dropped

Behaviour:
- Reset (rst=0, asynchronous):
  - we3=0, wa3=0, wd3=0, pc_wr_err=0.
  - FSM goes to LAST1, so req0 has priority on the first contest.
- Handshake:
  - A transfer occurs when reqN_valid && reqN_ready at a rising clk edge.
  - reqN_ready is combinational from valid, hold and FSM state.
  - A requester holds addr/data stable while valid && !ready.
  - valid must not be withdrawn before the transfer completes.
- Grant rules (evaluated each cycle, hold=0):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester not granted last gets ready=1.
  - None valid: both ready=0; FSM state unchanged.
  - hold=1: both ready=0; FSM unchanged; registered outputs load the no-write values.
- FSM (records last grant):
  - States: LAST0, LAST1.
  - A grant to req0 moves to LAST0; a grant to req1 moves to LAST1; otherwise the state holds.
- Output latency: exactly 1 cycle.
  - On the edge that accepts request N with addr != PC_IDX: we3<=1, wa3<=addr, wd3<=data, pc_wr_err<=0.
  - Accepted with addr == PC_IDX: we3<=0, wa3/wd3 unchanged, pc_wr_err<=1. The FSM still advances (the request is consumed).
  - No acceptance: we3<=0, pc_wr_err<=0, wa3/wd3 hold their previous values.
- Throughput: one write per cycle maximum. Back-to-back acceptances give continuous we3=1.
- Same address from both requesters in the same cycle: serialized by round-robin. The later write lands last and overwrites; no merging.
- Reset mid-operation: the pending registered write is discarded (we3 forced 0 immediately); requesters keep valid asserted and are re-arbitrated after release.
- Reset release: synchronized externally; the block assumes deassertion meets recovery timing.

Optional Feature:
- Macro WR_ARB_COUNT_EN.
- When defined, adds outputs cnt0 and cnt1, 16 bits each: per-requester counts of accepted, non-rejected writes.
  - Counters saturate at 16'hFFFF.
  - Reset to 0 asynchronously.
  - Updated on the same edge as we3.
- When not defined: no counter ports, no counter logic; behaviour is otherwise identical.

Decomposition:
- Shared package regfile_pkg:
  - typedef reg_addr_t (logic [3:0])
  - typedef word_t (logic [31:0])
  - localparam PC_IDX = 4'd15
  - enum arb_state_t {LAST0, LAST1}
- One natural sub-module: rr_arb2, a 2-input round-robin grant generator (valids, state in; one-hot grant out).
- Output register and PC check stay in the top.

Test Plan:
- Reset: hold rst=0 with req0_valid=1 -> req0_ready=0, we3=0, wa3=0, wd3=0; first cycle after rst=1 -> req0_ready=1.
- Single write: req0 addr=1, data=7, hold=0 -> req0_ready=1 that cycle; next cycle we3=1, wa3=1, wd3=7.
- Contention: both valid continuously, req0 addr=3 data=0xA, req1 addr=4 data=0xB -> grants alternate 0,1,0,1; we3 stays 1; wa3 sequence 3,4,3,4.
- PC reject: req1 addr=15, data=0x100 -> req1_ready=1; next cycle we3=0, pc_wr_err=1 for one cycle; register file unchanged.
- Hold: hold=1 for 3 cycles with both valid -> ready=0 and we3=0 throughout; on release the requester due by round-robin priority is granted first.
- Async reset mid-stream: assert rst=0 between clock edges while we3=1 -> we3 drops immediately without a clock edge; FSM returns to LAST1.
